// File: rtl/debug_pram_bridge.sv
// debug_pram_bridge
//   Turns the debugger's 32-bit program-RAM word reads and writes into two
//   16-bit halfword transactions on a wait-stated memory port. The low half
//   goes first, then the high half (little-endian). The bridge has one
//   active transaction plus a one-deep pending slot, a per-halfword ack
//   timeout, and sticky error flags.
// Ports:
//   clk, sync_reset                        clock, synchronous active-high reset
//   dbg_write_req/addr/data                one-cycle word write request
//   dbg_read_req/addr                      one-cycle word read request
//   dbg_read_done, dbg_read_data           read completion pulse and held word
//   mem_req/we/addr/wdata, mem_ack/rdata   halfword memory port
//   busy                                   transaction active or request pending
//   err_clear, overflow_err, timeout_err   sticky error flags and their clear
module debug_pram_bridge #(
   parameter int WORD_ADDR_WIDTH = 14,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       sync_reset,
   input  logic                       dbg_write_req,
   input  logic [WORD_ADDR_WIDTH-1:0] dbg_write_addr,
   input  logic [31:0]                dbg_write_data,
   input  logic                       dbg_read_req,
   input  logic [WORD_ADDR_WIDTH-1:0] dbg_read_addr,
   output logic                       dbg_read_done,
   output logic [31:0]                dbg_read_data,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [WORD_ADDR_WIDTH:0]   mem_addr,
   output logic [15:0]                mem_wdata,
   input  logic                       mem_ack,
   input  logic [15:0]                mem_rdata,
   output logic                       busy,
   input  logic                       err_clear,
   output logic                       overflow_err,
   output logic                       timeout_err
);

   localparam int             CW      = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0]  TMO_LIM = CW'(TIMEOUT_CYCLES);
   localparam logic           TMO_EN  = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

   typedef struct packed {
      logic                       we;
      logic [WORD_ADDR_WIDTH-1:0] addr;
      logic [31:0]                data;
   } req_t;

   state_t        state;
   req_t          act;
   req_t          pend;
   logic          pend_vld;
   logic [CW-1:0] wait_cnt;
   logic [15:0]   lo_half;

   req_t in_wr, in_rd, first;
   logic launch, pend_nxt_vld, drop, tmo;
   req_t launch_req, pend_nxt;

   assign busy = (state != IDLE) || pend_vld;

   // The write is ordered ahead of a simultaneous read. Each request takes
   // the next free position in this order: active register, then pending
   // slot. Anything left over is dropped.
   always_comb begin
      in_wr        = '{we: 1'b1, addr: dbg_write_addr, data: dbg_write_data};
      in_rd        = '{we: 1'b0, addr: dbg_read_addr,  data: 32'h0};
      first        = dbg_write_req ? in_wr : in_rd;
      launch       = 1'b0;
      launch_req   = pend;
      pend_nxt_vld = pend_vld;
      pend_nxt     = pend;
      drop         = 1'b0;
      if (state == IDLE) begin
         if (pend_vld) begin
            // The pending request launches first; the freed slot can take a new request.
            launch       = 1'b1;
            launch_req   = pend;
            pend_nxt_vld = 1'b0;
            if (dbg_write_req || dbg_read_req) begin
               pend_nxt_vld = 1'b1;
               pend_nxt     = first;
            end
            if (dbg_write_req && dbg_read_req) drop = 1'b1;
         end else begin
            if (dbg_write_req || dbg_read_req) begin
               launch     = 1'b1;
               launch_req = first;
            end
            if (dbg_write_req && dbg_read_req) begin
               pend_nxt_vld = 1'b1;
               pend_nxt     = in_rd;
            end
         end
      end else if (!pend_vld) begin
         if (dbg_write_req || dbg_read_req) begin
            pend_nxt_vld = 1'b1;
            pend_nxt     = first;
         end
         if (dbg_write_req && dbg_read_req) drop = 1'b1;
      end else begin
         if (dbg_write_req || dbg_read_req) drop = 1'b1;
      end
      // An ack in the same cycle the limit is reached still completes the halfword.
      tmo = ((state == LO) || (state == HI)) && !mem_ack && TMO_EN && (wait_cnt == TMO_LIM);
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state         <= IDLE;
         act           <= '0;
         pend          <= '0;
         pend_vld      <= 1'b0;
         wait_cnt      <= '0;
         lo_half       <= '0;
         dbg_read_done <= 1'b0;
         dbg_read_data <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         overflow_err  <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         pend_vld      <= pend_nxt_vld;
         pend          <= pend_nxt;
         dbg_read_done <= 1'b0;
         // A new error event wins over a clear that arrives in the same cycle.
         overflow_err  <= (overflow_err & ~err_clear) | drop;
         timeout_err   <= (timeout_err  & ~err_clear) | tmo;
         case (state)
            IDLE: begin
               if (launch) begin
                  state     <= LO;
                  act       <= launch_req;
                  mem_req   <= 1'b1;
                  mem_we    <= launch_req.we;
                  mem_addr  <= {launch_req.addr, 1'b0};
                  mem_wdata <= launch_req.data[15:0];
                  wait_cnt  <= '0;
               end
            end
            LO: begin
               if (mem_ack) begin
                  state     <= HI;
                  lo_half   <= mem_rdata;
                  mem_addr  <= {act.addr, 1'b1};
                  mem_wdata <= act.data[31:16];
                  wait_cnt  <= '0;
               end else if (tmo) begin
                  // Abort the whole word. A read still reports completion, with zero data.
                  mem_req <= 1'b0;
                  if (act.we) state <= IDLE;
                  else begin
                     state         <= RESP;
                     dbg_read_data <= '0;
                     dbg_read_done <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            HI: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  wait_cnt <= '0;
                  if (act.we) state <= IDLE;
                  else begin
                     state         <= RESP;
                     dbg_read_data <= {mem_rdata, lo_half};
                     dbg_read_done <= 1'b1;
                  end
               end else if (tmo) begin
                  mem_req <= 1'b0;
                  if (act.we) state <= IDLE;
                  else begin
                     state         <= RESP;
                     dbg_read_data <= '0;
                     dbg_read_done <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_pram_bridge.sv
// tb_debug_pram_bridge
//   Directed scenarios plus randomized word traffic for debug_pram_bridge
//   (TIMEOUT_CYCLES = 4). A halfword memory responder with selectable wait
//   states backs the memory port. A word-level reference memory predicts
//   the results of debugger reads.
module tb_debug_pram_bridge;

   logic        clk = 1'b0;
   logic        sync_reset;
   logic        dbg_write_req, dbg_read_req;
   logic [13:0] dbg_write_addr, dbg_read_addr;
   logic [31:0] dbg_write_data;
   logic        dbg_read_done;
   logic [31:0] dbg_read_data;
   logic        mem_req, mem_we, mem_ack;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        busy, err_clear, overflow_err, timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   // Responder configuration: fixed_wait < 0 selects random waits of 0..3 cycles.
   int  fixed_wait = 0;
   bit  no_ack     = 1'b0;

   logic [15:0] mem   [int];   // halfword memory, written only by the responder
   logic [31:0] model [int];   // word-level reference of debugger-visible contents
   logic [31:0] exp_q [$];     // expected read words, in completion order

   always #5 clk = ~clk;

   debug_pram_bridge #(.WORD_ADDR_WIDTH(14), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .sync_reset(sync_reset),
      .dbg_write_req(dbg_write_req), .dbg_write_addr(dbg_write_addr), .dbg_write_data(dbg_write_data),
      .dbg_read_req(dbg_read_req), .dbg_read_addr(dbg_read_addr),
      .dbg_read_done(dbg_read_done), .dbg_read_data(dbg_read_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .err_clear(err_clear), .overflow_err(overflow_err), .timeout_err(timeout_err)
   );

   function automatic logic [15:0] init_hw(input int h);
      return 16'(h * 40503 + 4951);
   endfunction

   function automatic logic [15:0] mem_rd(input int h);
      return mem.exists(h) ? mem[h] : init_hw(h);
   endfunction

   function automatic logic [31:0] model_rd(input int a);
      return model.exists(a) ? model[a] : {init_hw(2 * a + 1), init_hw(2 * a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [13:0] wa, input logic [31:0] wd,
                        input logic rd, input logic [13:0] ra);
      dbg_write_req  = wr;
      dbg_write_addr = wa;
      dbg_write_data = wd;
      dbg_read_req   = rd;
      dbg_read_addr  = ra;
      @(negedge clk);
      dbg_write_req  = 1'b0;
      dbg_read_req   = 1'b0;
   endtask

   // Run until the bridge is idle. Each read completion seen on the way is checked.
   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy || dbg_read_done) && n < budget) begin
         if (dbg_read_done) begin
            if (exp_q.size() == 0) chk({tag, "_unexp_done"}, 32'(dbg_read_done), 32'h0);
            else                   chk({tag, "_rdata"}, dbg_read_data, exp_q.pop_front());
         end
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'h0);
   endtask

   // Memory responder: drives ack and read data at the falling edge.
   initial begin
      int  wcnt = 0;
      int  cur_wait = 0;
      bit  fresh = 1'b1;
      int  h;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!mem_req || sync_reset) fresh = 1'b1;
         else begin
            if (fresh) begin
               fresh    = 1'b0;
               wcnt     = 0;
               cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
            if (!no_ack && wcnt == cur_wait) begin
               h         = int'(mem_addr);
               mem_ack   = 1'b1;
               mem_rdata = mem_rd(h);
               if (mem_we) mem[h] = mem_wdata;
               fresh     = 1'b1;
            end else wcnt++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          op;
      logic [13:0] wa, ra;
      logic [31:0] wd;
      sync_reset = 1'b1; err_clear = 1'b0;
      dbg_write_req = 1'b0; dbg_read_req = 1'b0;
      dbg_write_addr = '0; dbg_read_addr = '0; dbg_write_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(dbg_read_done), 32'h0);
      chk("rst_rdata", dbg_read_data, 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_errs", 32'({overflow_err, timeout_err}), 32'h0);
      sync_reset = 1'b0;
      @(negedge clk);

      // Zero-wait word write: low half, then high half, then idle.
      fixed_wait = 0;
      model[16] = 32'hDEADBEEF;
      issue(1'b1, 14'h0010, 32'hDEADBEEF, 1'b0, 14'h0);
      chk("wr_k1_req", 32'(mem_req), 32'h1);
      chk("wr_k1_we", 32'(mem_we), 32'h1);
      chk("wr_k1_addr", 32'(mem_addr), 32'h20);
      chk("wr_k1_wdata", 32'(mem_wdata), 32'hBEEF);
      chk("wr_k1_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("wr_k2_req", 32'(mem_req), 32'h1);
      chk("wr_k2_addr", 32'(mem_addr), 32'h21);
      chk("wr_k2_wdata", 32'(mem_wdata), 32'hDEAD);
      @(negedge clk);
      chk("wr_k3_busy", 32'(busy), 32'h0);
      chk("wr_k3_req", 32'(mem_req), 32'h0);
      chk("wr_mem_lo", 32'(mem_rd(32)), 32'hBEEF);
      chk("wr_mem_hi", 32'(mem_rd(33)), 32'hDEAD);

      // Load word 3, then read it back with 2 wait cycles per halfword: done at k+7.
      model[3] = 32'h12345678;
      issue(1'b1, 14'h3, 32'h12345678, 1'b0, 14'h0);
      wait_idle("ld3", 20);
      chk("ld3_mem_lo", 32'(mem_rd(6)), 32'h5678);
      fixed_wait = 2;
      issue(1'b0, 14'h0, 32'h0, 1'b1, 14'h3);
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("rd_wait_done_k%0d", c), 32'(dbg_read_done), 32'h0);
         @(negedge clk);
      end
      chk("rd_k7_done", 32'(dbg_read_done), 32'h1);
      chk("rd_k7_data", dbg_read_data, 32'h12345678);
      @(negedge clk);
      chk("rd_k8_done", 32'(dbg_read_done), 32'h0);
      chk("rd_k8_hold", dbg_read_data, 32'h12345678);
      chk("rd_k8_busy", 32'(busy), 32'h0);

      // Simultaneous write and read while idle: the write goes first.
      fixed_wait = 0;
      model[1] = 32'hAAAA5555;
      exp_q.push_back(model_rd(2));
      issue(1'b1, 14'h1, 32'hAAAA5555, 1'b1, 14'h2);
      chk("sim_first_we", 32'(mem_we), 32'h1);
      chk("sim_first_addr", 32'(mem_addr), 32'h2);
      wait_idle("sim", 20);
      chk("sim_ovf", 32'(overflow_err), 32'h0);
      chk("sim_mem", {16'(mem_rd(3)), 16'(mem_rd(2))}, 32'hAAAA5555);

      // Three requests while busy: the third one is dropped.
      fixed_wait = 1;
      model[5] = 32'h11112222;
      exp_q.push_back(32'h11112222);
      issue(1'b1, 14'h5, 32'h11112222, 1'b0, 14'h0);
      issue(1'b0, 14'h0, 32'h0, 1'b1, 14'h5);
      issue(1'b1, 14'h5, 32'h99999999, 1'b0, 14'h0);
      chk("ovf_set", 32'(overflow_err), 32'h1);
      wait_idle("ovf", 30);
      chk("ovf_sticky", 32'(overflow_err), 32'h1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("ovf_cleared", 32'(overflow_err), 32'h0);
      exp_q.push_back(model_rd(5));
      issue(1'b0, 14'h0, 32'h0, 1'b1, 14'h5);
      wait_idle("ovf_rb", 30);

      // Read with no ack ever: times out after LO cycles k+1..k+5.
      no_ack = 1'b1;
      @(negedge clk);
      issue(1'b0, 14'h0, 32'h0, 1'b1, 14'h4);
      repeat (4) @(negedge clk);
      chk("tmo_k5_req", 32'(mem_req), 32'h1);
      chk("tmo_k5_err", 32'(timeout_err), 32'h0);
      @(negedge clk);
      chk("tmo_k6_done", 32'(dbg_read_done), 32'h1);
      chk("tmo_k6_data", dbg_read_data, 32'h0);
      chk("tmo_k6_req", 32'(mem_req), 32'h0);
      chk("tmo_k6_err", 32'(timeout_err), 32'h1);
      no_ack = 1'b0;
      fixed_wait = 0;
      @(negedge clk);
      chk("tmo_k7_done", 32'(dbg_read_done), 32'h0);
      chk("tmo_k7_busy", 32'(busy), 32'h0);
      exp_q.push_back(model_rd(4));
      issue(1'b0, 14'h0, 32'h0, 1'b1, 14'h4);
      wait_idle("tmo_next", 20);
      chk("tmo_sticky", 32'(timeout_err), 32'h1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("tmo_cleared", 32'(timeout_err), 32'h0);

      // Reset during the HI half of a read, with a write waiting in the pending slot.
      fixed_wait = 3;
      issue(1'b0, 14'h0, 32'h0, 1'b1, 14'h6);
      issue(1'b1, 14'h7, 32'hCAFEF00D, 1'b0, 14'h0);
      repeat (4) @(negedge clk);
      chk("rst_hi_addr", 32'(mem_addr), 32'hD);
      chk("rst_hi_req", 32'(mem_req), 32'h1);
      sync_reset = 1'b1;
      @(negedge clk);
      sync_reset = 1'b0;
      chk("rst2_req", 32'(mem_req), 32'h0);
      chk("rst2_done", 32'(dbg_read_done), 32'h0);
      chk("rst2_busy", 32'(busy), 32'h0);
      chk("rst2_rdata", dbg_read_data, 32'h0);
      chk("rst2_mem_out", {15'h0, mem_we, mem_addr, 2'b00} | {16'h0, mem_wdata}, 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rst2_quiet_req%0d", c), 32'(mem_req), 32'h0);
         chk($sformatf("rst2_quiet_done%0d", c), 32'(dbg_read_done), 32'h0);
      end
      chk("rst2_mem7_untouched", 32'(mem_rd(14)), 32'(init_hw(14)));

      // Random word traffic against the reference memory.
      fixed_wait = -1;
      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 2));
         wa = 14'($urandom_range(0, 7));
         ra = 14'($urandom_range(0, 7));
         wd = $urandom();
         if (op != 1) model[int'(wa)] = wd;
         if (op != 0) exp_q.push_back(model_rd(int'(ra)));
         issue(op != 1, wa, wd, op != 0, ra);
         wait_idle("rand", 60);
      end
      chk("rand_q_empty", 32'(exp_q.size()), 32'h0);
      chk("rand_errs", 32'({overflow_err, timeout_err}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/debug_pram_bridge.md
# debug_pram_bridge

Sequences the on-chip debugger's 32-bit program-RAM word reads and writes onto a 16-bit, wait-stated memory port, two halfword transactions per word. Sits directly downstream of the debug coprocessor wrapper: it consumes that block's PRAM read/write requests and returns the read-data/enable pair the wrapper expects. It provides a one-deep pending slot, an ack timeout, and sticky error flags.

## Interface
- WORD_ADDR_WIDTH, 14, width of debugger word address; memory halfword address is WORD_ADDR_WIDTH+1 bits
- TIMEOUT_CYCLES, 255, wait cycles per halfword before abort; 0 disables timeout (counter 8 bits wide minimum, sized to hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  single clock, all logic on rising edge
- sync_reset  in  1  synchronous, active-high reset
- dbg_write_req  in  1  one-cycle write request (from wrapper pram_write_enable_out)
- dbg_write_addr  in  WORD_ADDR_WIDTH  word address
- dbg_write_data  in  32  word data
- dbg_read_req  in  1  one-cycle read request (from pram_read_enable_out)
- dbg_read_addr  in  WORD_ADDR_WIDTH  word address
- dbg_read_done  out  1  one-cycle pulse, read data valid (to pram_read_enable_in)
- dbg_read_data  out  32  read word, held until next read completes (to pram_read_data_in)
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  WORD_ADDR_WIDTH+1  halfword address
- mem_wdata  out  16  write halfword
- mem_ack  in  1  memory completes current halfword this cycle
- mem_rdata  in  16  read halfword, valid when mem_ack=1
- busy  out  1  state != IDLE or pending slot valid
- err_clear  in  1  clears sticky flags
- overflow_err  out  1  sticky: request dropped
- timeout_err  out  1  sticky: halfword timed out

## Operation
- Word split, little-endian: low half dbg_data[15:0] at {addr,0}, high half dbg_data[31:16] at {addr,1}.
- States: IDLE, LO (low half), HI (high half), RESP (read done pulse).
- Request capture: each incoming request (type, addr, data) is latched into the active register if IDLE and no pending; otherwise into the pending slot if empty; otherwise dropped and overflow_err set.
- Simultaneous dbg_write_req and dbg_read_req: write is taken first (active or pending); read goes into the next free position; if none, read dropped, overflow_err set.
- In IDLE with pending valid: pending launches (priority over inputs); a new request in the same cycle may fill the freed pending slot.
- IDLE→LO on launch. LO: mem_req=1, mem_addr={addr,0}, mem_we=type; on mem_ack → HI (read: low half latched). HI: mem_addr={addr,1}; on mem_ack → write: IDLE; read: RESP with dbg_read_data={mem_rdata, low}. RESP→IDLE, dbg_read_done=1 for that one cycle.
- mem_req/mem_addr/mem_we/mem_wdata stable while mem_req=1 and mem_ack=0; mem_req=0 in IDLE and RESP.
- Timeout: wait counter clears on entry to LO/HI and on each ack; increments each LO/HI cycle without ack. When it equals TIMEOUT_CYCLES (non-zero): set timeout_err, mem_req drops next cycle; write → IDLE; read → RESP with dbg_read_data=0.
- err_clear clears both flags; a same-cycle error event wins (flag stays set).
- Reset: state IDLE, pending empty, counter 0; all outputs 0, including dbg_read_data. Reset mid-transaction abandons it without completion pulse; mem_req low on the cycle after reset is sampled.

## Timing
- Request sampled at edge k → LO from k+1. With zero-wait memory (mem_ack=1 in LO and HI): HI at k+2; write returns to IDLE at k+3; read dbg_read_done=1 in cycle k+3, IDLE at k+4.
- Each wait cycle on mem_ack adds exactly one cycle to latency.
- busy rises the cycle after the request is sampled and falls in the first IDLE cycle with pending empty.
- Back-to-back: pending request launches on the first IDLE cycle; there is no extra bubble beyond that IDLE cycle.

## Test plan
- Write addr 0x0010, data 0xDEADBEEF, zero-wait memory -> halfword writes 0xBEEF @0x0020 then 0xDEAD @0x0021 in cycles k+1,k+2; busy low at k+3.
- Read addr 0x0003, memory returns 0x5678 then 0x1234 with 2 wait cycles each -> dbg_read_done single pulse at k+7, dbg_read_data=0x12345678.
- Simultaneous write(0x1,0xAAAA5555)+read(0x2) while idle -> write completes first, then read; no overflow_err.
- Three requests while busy -> third dropped, overflow_err=1 until err_clear; first two complete correctly.
- mem_ack never asserted on read, TIMEOUT_CYCLES=4 -> timeout_err=1, dbg_read_done pulse with data 0, mem_req low afterwards, next request serviced normally.
- sync_reset asserted in HI of a read -> no dbg_read_done pulse, mem_req=0 next cycle, all outputs 0, pending cleared.
